traffic_countdown_ctrl: RTL and testbench

//  Parametrised traffic-light phase controller with an N-digit BCD countdown display.

---
 rtl/traffic_countdown_ctrl.sv | 167 ++++++++++++++++
 tb/tb_traffic_countdown_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_countdown_ctrl.sv
// Traffic-light phase controller (GREEN -> YELLOW -> RED) with an N-digit BCD
// countdown, hold, latched pedestrian request and per-digit 7-segment decode.
module traffic_countdown_ctrl #(
    parameter int unsigned         DIGITS     = 2,
    parameter logic [4*DIGITS-1:0] GREEN_BCD  = 'h19,
    parameter logic [4*DIGITS-1:0] YELLOW_BCD = 'h03,
    parameter logic [4*DIGITS-1:0] RED_BCD    = 'h15,
    parameter logic [4*DIGITS-1:0] PED_BCD    = 'h05
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tick_en_i,
    input  logic                  hold_i,
    input  logic                  ped_req_i,
    output logic                  led_green_o,
    output logic                  led_yellow_o,
    output logic                  led_red_o,
    output logic [4*DIGITS-1:0]   bcd_count_o,
    output logic [7*DIGITS-1:0]   seg_o,
    output logic                  phase_done_o
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        PhGreen  = 2'd0,
        PhYellow = 2'd1,
        PhRed    = 2'd2
    } phase_e;

    function automatic logic isBcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Digit-serial borrow; only called with a non-zero count so it never wraps.
    function automatic logic [W-1:0] bcdDec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    if (DIGITS < 1 || DIGITS > 4) begin : g_err_digits
        $error("traffic_countdown_ctrl: DIGITS must be 1..4");
    end
    if (!isBcd(GREEN_BCD) || !isBcd(YELLOW_BCD) || !isBcd(RED_BCD) || !isBcd(PED_BCD)) begin : g_err_bcd
        $error("traffic_countdown_ctrl: duration digit above 9");
    end
    if (GREEN_BCD == '0 || YELLOW_BCD == '0 || RED_BCD == '0) begin : g_err_zero
        $error("traffic_countdown_ctrl: phase duration must be at least 1");
    end
    if (PED_BCD >= GREEN_BCD) begin : g_err_ped
        $error("traffic_countdown_ctrl: PED_BCD must be below GREEN_BCD");
    end

    phase_e         phase_q, phase_d;
    logic [W-1:0]   count_q, count_d;
    logic           pedLatch_q, pedLatch_d;
    logic           phaseDone_q, phaseDone_d;
    logic           ledGreen_q, ledGreen_d;
    logic           ledYellow_q, ledYellow_d;
    logic           ledRed_q, ledRed_d;
    logic           advance;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q     <= PhGreen;
            count_q     <= GREEN_BCD;
            pedLatch_q  <= 1'b0;
            phaseDone_q <= 1'b0;
            ledGreen_q  <= 1'b1;
            ledYellow_q <= 1'b0;
            ledRed_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            count_q     <= count_d;
            pedLatch_q  <= pedLatch_d;
            phaseDone_q <= phaseDone_d;
            ledGreen_q  <= ledGreen_d;
            ledYellow_q <= ledYellow_d;
            ledRed_q    <= ledRed_d;
        end
    end

    // A request on an advance edge is only seen via pedLatch_q on the following advance.
    always_comb begin
        advance     = tick_en_i & ~hold_i;
        phase_d     = phase_q;
        count_d     = count_q;
        pedLatch_d  = pedLatch_q | ped_req_i;
        phaseDone_d = 1'b0;
        if (advance) begin
            if (count_q == '0) begin
                phaseDone_d = 1'b1;
                unique case (phase_q)
                    PhGreen: begin
                        phase_d    = PhYellow;
                        count_d    = YELLOW_BCD;
                        pedLatch_d = ped_req_i;
                    end
                    PhYellow: begin
                        phase_d = PhRed;
                        count_d = RED_BCD;
                    end
                    default: begin
                        phase_d = PhGreen;
                        count_d = GREEN_BCD;
                    end
                endcase
            end else if (phase_q == PhGreen && pedLatch_q && count_q > PED_BCD) begin
                count_d = PED_BCD;
            end else begin
                count_d = bcdDec(count_q);
            end
        end
        ledGreen_d  = (phase_d == PhGreen);
        ledYellow_d = (phase_d == PhYellow);
        ledRed_d    = (phase_d == PhRed);
    end

    always_comb begin
        led_green_o  = ledGreen_q;
        led_yellow_o = ledYellow_q;
        led_red_o    = ledRed_q;
        bcd_count_o  = count_q;
        phase_done_o = phaseDone_q;
        seg_o        = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_o[7*i +: 7] = seg7(count_q[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_traffic_countdown_ctrl.sv
// Self-checking bench for traffic_countdown_ctrl: vector table, directed corner
// sequences and randomized stimulus against an integer-level reference model.
module tb_traffic_countdown_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick_en = 1'b0;
    logic        hold = 1'b0;
    logic        ped_req = 1'b0;
    logic        led_green, led_yellow, led_red, phase_done;
    logic [7:0]  bcd_count;
    logic [13:0] seg;

    logic        tick3 = 1'b0;
    logic        hold3 = 1'b0;
    logic        ped3 = 1'b0;
    logic        g3, y3, r3, done3;
    logic [11:0] bcd3;
    logic [20:0] seg3;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_countdown_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_en_i(tick_en), .hold_i(hold), .ped_req_i(ped_req),
        .led_green_o(led_green), .led_yellow_o(led_yellow), .led_red_o(led_red),
        .bcd_count_o(bcd_count), .seg_o(seg), .phase_done_o(phase_done)
    );

    traffic_countdown_ctrl #(
        .DIGITS(3), .GREEN_BCD(12'h100), .YELLOW_BCD(12'h003),
        .RED_BCD(12'h015), .PED_BCD(12'h005)
    ) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .tick_en_i(tick3), .hold_i(hold3), .ped_req_i(ped3),
        .led_green_o(g3), .led_yellow_o(y3), .led_red_o(r3),
        .bcd_count_o(bcd3), .seg_o(seg3), .phase_done_o(done3)
    );

    // Reference model: phase index 0/1/2 = green/yellow/red, remaining time as an integer.
    int mPhase, mRemain;
    bit mLatch, mDone;
    int dur[3] = '{19, 3, 15};
    localparam int PedTime = 5;

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] segOf(input logic [3:0] d);
        logic [6:0] t[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d <= 4'd9) ? t[d] : 7'h00;
    endfunction

    function automatic logic [2:0] lampsOf(input int p);
        return (p == 0) ? 3'b100 : (p == 1) ? 3'b010 : 3'b001;
    endfunction

    task automatic modelReset();
        mPhase = 0; mRemain = dur[0]; mLatch = 0; mDone = 0;
    endtask

    task automatic modelStep(input bit t, input bit h, input bit p);
        bit oldLatch;
        oldLatch = mLatch;
        mDone = 0;
        if (p) mLatch = 1;
        if (t && !h) begin
            if (mRemain == 0) begin
                mPhase  = (mPhase + 1) % 3;
                mRemain = dur[mPhase];
                mDone   = 1;
                if (mPhase == 1) mLatch = p;
            end else if (mPhase == 0 && oldLatch && mRemain > PedTime) begin
                mRemain = PedTime;
            end else begin
                mRemain = mRemain - 1;
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [7:0]  eb;
        logic [25:0] act, exp;
        eb  = toBcd(mRemain);
        act = {bcd_count, led_green, led_yellow, led_red, phase_done, seg};
        exp = {eb, lampsOf(mPhase), mDone, segOf(eb[7:4]), segOf(eb[3:0])};
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got count=%h lamps=%b done=%b seg=%h, expected count=%h lamps=%b done=%b seg=%h",
                     name, bcd_count, {led_green, led_yellow, led_red}, phase_done, seg,
                     eb, lampsOf(mPhase), mDone, exp[13:0]);
        end
    endtask

    task automatic applyStimulus(input bit t, input bit h, input bit p);
        tick_en = t; hold = h; ped_req = p;
        @(posedge clk);
        modelStep(t, h, p);
        #1;
        tick_en = 1'b0; hold = 1'b0; ped_req = 1'b0;
    endtask

    task automatic doReset();
        tick_en = 1'b0; hold = 1'b0; ped_req = 1'b0;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic advanceTo(input int p, input int r);
        for (int i = 0; i < 100 && !(mPhase == p && mRemain == r); i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("walk");
        end
        tests++;
        if (!(mPhase == p && mRemain == r)) begin
            failures++;
            $display("[TB] FAIL walk_timeout: got phase %0d count %0d, expected phase %0d count %0d",
                     mPhase, mRemain, p, r);
        end
    endtask

    typedef struct {
        bit         tick;
        bit         hold;
        bit         ped;
        logic [7:0] expCount;
        logic [2:0] expLamps;
        bit         expDone;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int pulses;
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h19, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h18, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h18, 3'b100, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h18, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h05, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h04, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h03, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h02, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h01, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 3'b100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h03, 3'b010, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h03, 3'b010, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h02, 3'b010, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h01, 3'b010, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'b010, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h15, 3'b001, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h14, 3'b001, 1'b0});

        #2;
        doReset();
        checkValue("reset_state", 32'({bcd_count, led_green, led_yellow, led_red, phase_done}),
                   32'({8'h19, 3'b100, 1'b0}));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkValue("idle_no_tick", 32'({bcd_count, led_green}), 32'({8'h19, 1'b1}));
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].tick, vecs[i].hold, vecs[i].ped);
            checkValue($sformatf("vec%0d", i),
                       32'({bcd_count, led_green, led_yellow, led_red, phase_done}),
                       32'({vecs[i].expCount, vecs[i].expLamps, vecs[i].expDone}));
            checkOutput("vec_model");
        end

        // Full light cycle: 20 green + 4 yellow + 16 red advance edges.
        doReset();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("cycle");
            if (phase_done) pulses++;
            checkValue("cycle_onehot", 32'($onehot({led_green, led_yellow, led_red})), 32'd1);
        end
        checkValue("cycle_pulses", 32'(pulses), 32'd3);
        checkValue("cycle_end", 32'({bcd_count, led_green}), 32'({8'h19, 1'b1}));

        // Borrow across digits.
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("borrow_10", 32'(bcd_count), 32'h10);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("borrow_09", 32'(bcd_count), 32'h09);
        doReset();
        checkValue("dig3_reset", 32'(bcd3), 32'h100);
        tick3 = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("dig3_099", 32'({bcd3, seg3}), 32'({12'h099, 7'h3F, 7'h6F, 7'h6F}) & 32'hFFFF_FFFF);
        tick3 = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("dig3_098", 32'(bcd3), 32'h098);
        tick3 = 1'b0;

        // Pedestrian at green 15 shortens to 05.
        doReset();
        advanceTo(0, 15);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkValue("ped15_latched", 32'(bcd_count), 32'h15);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("ped15_to05", 32'(bcd_count), 32'h05);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("ped15_to04", 32'(bcd_count), 32'h04);

        // Pedestrian at green 03 has no effect on the count.
        doReset();
        advanceTo(0, 3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("ped03_to02", 32'(bcd_count), 32'h02);

        // Pedestrian during red shortens the next green on its first tick.
        doReset();
        advanceTo(2, 10);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkValue("pedred_09", 32'({bcd_count, led_red}), 32'({8'h09, 1'b1}));
        advanceTo(0, 19);
        checkValue("pedred_green19", 32'({bcd_count, led_green}), 32'({8'h19, 1'b1}));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("pedred_to05", 32'(bcd_count), 32'h05);

        // Hold freezes count and suppresses phase changes.
        doReset();
        advanceTo(0, 12);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkValue("hold12", 32'({bcd_count, phase_done}), 32'({8'h12, 1'b0}));
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("hold_release_11", 32'(bcd_count), 32'h11);
        advanceTo(0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkValue("hold_at_00", 32'({bcd_count, led_green, phase_done}), 32'({8'h00, 1'b1, 1'b0}));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("after_hold_yellow", 32'({bcd_count, led_yellow, phase_done}), 32'({8'h03, 1'b1, 1'b1}));

        // Asynchronous reset in red at 07.
        advanceTo(2, 7);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkValue("midred_reset", 32'({bcd_count, led_green, led_yellow, led_red, phase_done}),
                   32'({8'h19, 3'b100, 1'b0}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("midred_resume_18", 32'(bcd_count), 32'h18);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                              $urandom_range(0, 19) == 0);
                checkOutput("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
